// File: rtl/psu_seq_pkg.sv
// Shared types and constants for the PSU rail sequencer.
// Rail index map: 12 V, 3.3 V, feedback, 5 V, 15 V.
package psu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RAMP_PG    = 3'd1,
    RAMP_DWELL = 3'd2,
    ON         = 3'd3,
    DOWN       = 3'd4,
    FAULT      = 3'd5
  } seq_state_t;

  localparam int RAIL_IDX_W = 3;

  localparam logic [RAIL_IDX_W-1:0] RAIL_12 = 3'd0;
  localparam logic [RAIL_IDX_W-1:0] RAIL_33 = 3'd1;
  localparam logic [RAIL_IDX_W-1:0] RAIL_FB = 3'd2;
  localparam logic [RAIL_IDX_W-1:0] RAIL_5  = 3'd3;
  localparam logic [RAIL_IDX_W-1:0] RAIL_15 = 3'd4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/psu_pg_debounce.sv
// Single-bit power-good qualifier: 2-flop synchronizer followed by a
// stability filter that only follows the input after PG_DEBOUNCE stable cycles.
module psu_pg_debounce #(
  parameter int PG_DEBOUNCE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pg_raw,
  output logic pg_qual
);

  localparam int CW = (PG_DEBOUNCE > 1) ? $clog2(PG_DEBOUNCE + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PG_DEBOUNCE - 1);

  logic [1:0]    sync_q, sync_d;
  logic          qual_q, qual_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[0], pg_raw};
    qual_d = qual_q;
    cnt_d  = '0;
    // Count consecutive cycles the synchronized value disagrees with the output.
    if (sync_q[1] != qual_q) begin
      if (cnt_q == CNT_LAST) begin
        qual_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      qual_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      qual_q <= qual_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pg_qual = qual_q;

endmodule

// File: rtl/psu_rail_sequencer.sv
// Five-rail power sequencer: ordered ramp-up with pg timeout, reverse power-down,
// runtime pg monitoring and first-fault latch. Define PSU_SEQ_PG_DEBOUNCE_EN to debounce pg.
module psu_rail_sequencer
  import psu_seq_pkg::*;
#(
  parameter int N_RAILS     = 5,
  parameter int STEP_DLY    = 400,
  parameter int PG_TIMEOUT  = 4000,
  parameter int PG_DEBOUNCE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr_fault,
  input  logic [N_RAILS-1:0]    pg,
  output logic [N_RAILS-1:0]    rail_en,
  output logic                  power_ok,
  output logic                  busy,
  output logic                  fault,
  output logic [RAIL_IDX_W-1:0] fault_rail
);

  localparam int CNT_W = max_int(1, $clog2(max_int(STEP_DLY, PG_TIMEOUT)));
  localparam logic [CNT_W-1:0]      STEP_LAST = CNT_W'(STEP_DLY - 1);
  localparam logic [CNT_W-1:0]      PG_LAST   = CNT_W'(PG_TIMEOUT - 1);
  localparam logic [RAIL_IDX_W-1:0] IDX_LAST  = RAIL_IDX_W'(N_RAILS - 1);

  logic [N_RAILS-1:0] pg_qual;

`ifdef PSU_SEQ_PG_DEBOUNCE_EN
  generate
    for (genvar gi = 0; gi < N_RAILS; gi++) begin : g_pg_db
      psu_pg_debounce #(.PG_DEBOUNCE(PG_DEBOUNCE)) u_pg_db (
        .clk    (clk),
        .rst    (rst),
        .pg_raw (pg[gi]),
        .pg_qual(pg_qual[gi])
      );
    end
  endgenerate
`else
  assign pg_qual = pg;
`endif

  seq_state_t            state_q, state_d;
  logic [RAIL_IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [N_RAILS-1:0]    rail_en_q, rail_en_d;
  logic [RAIL_IDX_W-1:0] fault_rail_q, fault_rail_d;
  logic                  power_ok_q, busy_q, fault_q;
  logic                  mon_fault;
  logic [RAIL_IDX_W-1:0] mon_rail;

  always_comb begin
    mon_fault = 1'b0;
    mon_rail  = '0;
    // Descending scan so the lowest failing rail is the one reported.
    for (int j = N_RAILS - 1; j >= 0; j--) begin
      if (rail_en_q[j] && !pg_qual[j] &&
          !(state_q == RAMP_PG && idx_q == RAIL_IDX_W'(j))) begin
        mon_fault = 1'b1;
        mon_rail  = RAIL_IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    rail_en_d    = rail_en_q;
    fault_rail_d = fault_rail_q;
    unique case (state_q)
      IDLE: begin
        rail_en_d = '0;
        if (en) begin
          state_d   = RAMP_PG;
          idx_d     = '0;
          cnt_d     = '0;
          rail_en_d = N_RAILS'(1);
        end
      end
      RAMP_PG: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mon_fault) begin
          state_d      = FAULT;
          rail_en_d    = '0;
          fault_rail_d = mon_rail;
        end else if (!pg_qual[idx_q] && cnt_q == PG_LAST) begin
          state_d      = FAULT;
          rail_en_d    = '0;
          fault_rail_d = idx_q;
        end else if (!en) begin
          state_d          = DOWN;
          rail_en_d[idx_q] = 1'b0;
          cnt_d            = '0;
        end else if (pg_qual[idx_q]) begin
          state_d = RAMP_DWELL;
          cnt_d   = '0;
        end
      end
      RAMP_DWELL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mon_fault) begin
          state_d      = FAULT;
          rail_en_d    = '0;
          fault_rail_d = mon_rail;
        end else if (!en) begin
          state_d          = DOWN;
          rail_en_d[idx_q] = 1'b0;
          cnt_d            = '0;
        end else if (cnt_q == STEP_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ON;
          end else begin
            state_d                         = RAMP_PG;
            idx_d                           = idx_q + RAIL_IDX_W'(1);
            rail_en_d[idx_q+RAIL_IDX_W'(1)] = 1'b1;
          end
        end
      end
      ON: begin
        if (mon_fault) begin
          state_d      = FAULT;
          rail_en_d    = '0;
          fault_rail_d = mon_rail;
        end else if (!en) begin
          // Rails are enabled contiguously from 0, so idx is the highest set bit.
          state_d          = DOWN;
          rail_en_d[idx_q] = 1'b0;
          cnt_d            = '0;
        end
      end
      DOWN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == STEP_LAST) begin
          cnt_d = '0;
          if (idx_q != '0) begin
            idx_d                           = idx_q - RAIL_IDX_W'(1);
            rail_en_d[idx_q-RAIL_IDX_W'(1)] = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FAULT: begin
        rail_en_d = '0;
        if (clr_fault && !en) begin
          state_d      = IDLE;
          fault_rail_d = '0;
          idx_d        = '0;
          cnt_d        = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        rail_en_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      rail_en_q    <= '0;
      fault_rail_q <= '0;
      power_ok_q   <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      rail_en_q    <= rail_en_d;
      fault_rail_q <= fault_rail_d;
      power_ok_q   <= (state_d == ON);
      busy_q       <= (state_d == RAMP_PG) || (state_d == RAMP_DWELL) || (state_d == DOWN);
      fault_q      <= (state_d == FAULT);
    end
  end

  assign rail_en    = rail_en_q;
  assign power_ok   = power_ok_q;
  assign busy       = busy_q;
  assign fault      = fault_q;
  assign fault_rail = fault_rail_q;

endmodule

// File: tb/tb_psu_rail_sequencer.sv
// Directed bench for psu_rail_sequencer with STEP_DLY=4, PG_TIMEOUT=8, no debounce.
// A pg model raises pg[i] so the DUT sees it 2 edges after rail_en[i] rises.
module tb_psu_rail_sequencer;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         clr_fault = 1'b0;
  logic [N-1:0] pg = '0;
  logic [N-1:0] rail_en;
  logic         power_ok, busy, fault;
  logic [2:0]   fault_rail;

  logic [N-1:0] hold_low = '0;
  int           age [N];
  int           n_cmp = 0;
  int           n_err = 0;

  psu_rail_sequencer #(
    .N_RAILS    (N),
    .STEP_DLY   (4),
    .PG_TIMEOUT (8),
    .PG_DEBOUNCE(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr_fault (clr_fault),
    .pg        (pg),
    .rail_en   (rail_en),
    .power_ok  (power_ok),
    .busy      (busy),
    .fault     (fault),
    .fault_rail(fault_rail)
  );

  always #5 clk = ~clk;

  // pg model: updated 1 time unit after each rising edge.
  initial begin
    for (int i = 0; i < N; i++) age[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (rail_en[i]) age[i] = (age[i] < 1000) ? age[i] + 1 : age[i];
        else            age[i] = 0;
        pg[i] = (age[i] >= 2) && !hold_low[i];
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rail_en"}, 32'(rail_en), 32'd0);
    chk({tag, "_power_ok"}, 32'(power_ok), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_fault_rail"}, 32'(fault_rail), 32'd0);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk_all_zero("idle");

    // 1. Power-up: one rail every 6 edges, power_ok 6 edges after rail 4
    en = 1'b1;
    tick();
    chk("up_rail0", 32'(rail_en), 32'h01);
    chk("up_busy0", 32'(busy), 32'd1);
    for (int k = 1; k < N; k++) begin
      for (int c = 1; c <= 6; c++) begin
        tick();
        chk("up_busy", 32'(busy), 32'd1);
        if (c == 5) chk("up_hold", 32'(rail_en), 32'((1 << k) - 1));
      end
      chk("up_step", 32'(rail_en), 32'((1 << (k + 1)) - 1));
    end
    for (int c = 1; c <= 5; c++) tick();
    chk("up_pok_early", 32'(power_ok), 32'd0);
    tick();
    chk("up_pok", 32'(power_ok), 32'd1);
    chk("up_busy_on", 32'(busy), 32'd0);
    chk("up_rails_on", 32'(rail_en), 32'h1f);

    // 4. Power-down: rail 4 on the first edge, then one per 4 edges
    en = 1'b0;
    tick();
    chk("dn_rail4", 32'(rail_en), 32'h0f);
    chk("dn_pok", 32'(power_ok), 32'd0);
    chk("dn_busy", 32'(busy), 32'd1);
    for (int k = 3; k >= 0; k--) begin
      for (int c = 1; c <= 3; c++) tick();
      chk("dn_hold", 32'(rail_en), 32'((1 << (k + 1)) - 1));
      tick();
      chk("dn_step", 32'(rail_en), 32'((1 << k) - 1));
    end
    for (int c = 1; c <= 3; c++) tick();
    chk("dn_busy_hold", 32'(busy), 32'd1);
    tick();
    chk("dn_busy_end", 32'(busy), 32'd0);
    chk("dn_fault", 32'(fault), 32'd0);

    // 3. Runtime pg loss on rail 3 while ON
    en = 1'b1;
    for (int c = 1; c <= 31; c++) tick();
    chk("rt_on", 32'(power_ok), 32'd1);
    hold_low[3] = 1'b1;
    tick();
    chk("rt_pok_before", 32'(power_ok), 32'd1);
    tick();
    chk("rt_fault", 32'(fault), 32'd1);
    chk("rt_fault_rail", 32'(fault_rail), 32'd3);
    chk("rt_rail_en", 32'(rail_en), 32'd0);
    chk("rt_pok", 32'(power_ok), 32'd0);
    chk("rt_busy", 32'(busy), 32'd0);

    // 5. Fault clear needs en=0
    clr_fault = 1'b1;
    tick();
    tick();
    chk("clr_en1_fault", 32'(fault), 32'd1);
    chk("clr_en1_rail", 32'(fault_rail), 32'd3);
    chk("clr_en1_rail_en", 32'(rail_en), 32'd0);
    en = 1'b0;
    tick();
    chk_all_zero("clr");
    clr_fault = 1'b0;
    hold_low = '0;
    tick();
    chk_all_zero("clr_idle");

    // 2. Timeout on rail 2
    hold_low[2] = 1'b1;
    en = 1'b1;
    tick();
    chk("to_rail0", 32'(rail_en), 32'h01);
    for (int c = 1; c <= 12; c++) tick();
    chk("to_rail2", 32'(rail_en), 32'h07);
    for (int c = 1; c <= 7; c++) tick();
    chk("to_fault_early", 32'(fault), 32'd0);
    chk("to_rail_en_early", 32'(rail_en), 32'h07);
    tick();
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_fault_rail", 32'(fault_rail), 32'd2);
    chk("to_rail_en", 32'(rail_en), 32'd0);
    en = 1'b0;
    clr_fault = 1'b1;
    tick();
    chk("to_clr", 32'(fault), 32'd0);
    clr_fault = 1'b0;
    hold_low = '0;
    tick();

    // 6. Reset mid-ramp, then ramp restarts with en held
    en = 1'b1;
    tick();
    for (int c = 1; c <= 6; c++) tick();
    chk("rs_mid", 32'(rail_en), 32'h03);
    rst = 1'b1;
    tick();
    chk_all_zero("rs");
    rst = 1'b0;
    tick();
    chk("rs_restart", 32'(rail_en), 32'h01);
    chk("rs_busy", 32'(busy), 32'd1);
    for (int c = 1; c <= 6; c++) tick();
    chk("rs_rail1", 32'(rail_en), 32'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
